// File: rtl/word_sync_rx_pkg.sv
// Shared types and default sizes for the word_sync_rx receiver.
package word_sync_rx_pkg;

  localparam int unsigned DWIDTH_DEF      = 32;
  localparam int unsigned SYNC_STAGES_DEF = 2;
  localparam int unsigned CNT_W_DEF       = 16;

  // MASK: post-reset resync window, IDLE: waiting for a word, HOLD: word presented.
  typedef enum logic [1:0] {
    MASK = 2'd0,
    IDLE = 2'd1,
    HOLD = 2'd2
  } state_e;

endpackage

// File: rtl/sync_bit.sv
// Multi-flop single-bit synchronizer into the dclk domain.
module sync_bit #(
  parameter int unsigned STAGES = 2
) (
  input  logic dclk,
  input  logic drst,
  input  logic din,
  output logic dout
);

  logic [STAGES-1:0] r_chain;

  // Shift the asynchronous input through the flop chain.
  always_ff @(posedge dclk) begin
    if (drst) begin
      r_chain <= '0;
    end else begin
      r_chain <= {r_chain[STAGES-2:0], din};
    end
  end

  assign dout = r_chain[STAGES-1];

endmodule

// File: rtl/word_sync_rx.sv
// Toggle-handshake word receiver: synchronizes req_tgl, captures req_data,
// presents it with valid/ready and returns ack_tgl on acceptance.
module word_sync_rx
  import word_sync_rx_pkg::*;
#(
  parameter int unsigned DWIDTH      = DWIDTH_DEF,
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int unsigned CNT_W       = CNT_W_DEF
) (
  input  logic              dclk,
  input  logic              drst,
  input  logic              req_tgl,
  input  logic [DWIDTH-1:0] req_data,
  output logic              ack_tgl,
  output logic [DWIDTH-1:0] dout,
  output logic              dout_vld,
  input  logic              dout_rdy,
  output logic [CNT_W-1:0]  word_cnt,
  output logic              proto_err
);

  localparam int unsigned   MW       = $clog2(SYNC_STAGES + 2);
  localparam logic [MW-1:0] MaskLoad = MW'(SYNC_STAGES + 1);
  localparam logic [MW-1:0] MaskOne  = MW'(1);

  logic              w_req_s;
  logic              r_req_p;
  logic              w_edge;
  logic              w_accept;
  state_e            r_state,    w_state_nxt;
  logic [MW-1:0]     r_mask_cnt, w_mask_cnt_nxt;
  logic              r_ack,      w_ack_nxt;
  logic [DWIDTH-1:0] r_dout,     w_dout_nxt;
  logic              r_vld,      w_vld_nxt;
  logic [CNT_W-1:0]  r_cnt,      w_cnt_nxt;
  logic              r_err,      w_err_nxt;

  sync_bit #(
    .STAGES (SYNC_STAGES)
  ) u_sync_req (
    .dclk (dclk),
    .drst (drst),
    .din  (req_tgl),
    .dout (w_req_s)
  );

  assign w_edge   = w_req_s ^ r_req_p;
  assign w_accept = r_vld & dout_rdy;

  // Next-state and datapath decisions for the handshake FSM.
  always_comb begin
    w_state_nxt    = r_state;
    w_mask_cnt_nxt = r_mask_cnt;
    w_ack_nxt      = r_ack;
    w_dout_nxt     = r_dout;
    w_vld_nxt      = r_vld;
    w_cnt_nxt      = r_cnt;
    w_err_nxt      = r_err;
    unique case (r_state)
      MASK: begin
        // Edges are meaningless until the chain has flushed; adopt the current level as ack.
        if (r_mask_cnt == MaskOne) begin
          w_state_nxt = IDLE;
          w_ack_nxt   = w_req_s;
        end else begin
          w_mask_cnt_nxt = r_mask_cnt - MaskOne;
        end
      end
      IDLE: begin
        if (w_edge) begin
          w_dout_nxt  = req_data;
          w_state_nxt = HOLD;
        end
      end
      HOLD: begin
        // Any edge here, including in the acceptance cycle, is a dropped request.
        if (w_edge) begin
          w_err_nxt = 1'b1;
        end
        if (w_accept) begin
          w_vld_nxt   = 1'b0;
          w_ack_nxt   = ~r_ack;
          w_cnt_nxt   = r_cnt + 1'b1;
          w_state_nxt = IDLE;
        end else begin
          w_vld_nxt = 1'b1;
        end
      end
      default: begin
        w_state_nxt    = MASK;
        w_mask_cnt_nxt = MaskLoad;
      end
    endcase
  end

  // State register with synchronous reset.
  always_ff @(posedge dclk) begin
    if (drst) begin
      r_state    <= MASK;
      r_mask_cnt <= MaskLoad;
      r_req_p    <= 1'b0;
      r_ack      <= 1'b0;
      r_dout     <= '0;
      r_vld      <= 1'b0;
      r_cnt      <= '0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_mask_cnt <= w_mask_cnt_nxt;
      r_req_p    <= w_req_s;
      r_ack      <= w_ack_nxt;
      r_dout     <= w_dout_nxt;
      r_vld      <= w_vld_nxt;
      r_cnt      <= w_cnt_nxt;
      r_err      <= w_err_nxt;
    end
  end

  assign ack_tgl   = r_ack;
  assign dout      = r_dout;
  assign dout_vld  = r_vld;
  assign word_cnt  = r_cnt;
  assign proto_err = r_err;

endmodule

// File: tb/tb_word_sync_rx.sv
// Self-checking bench for word_sync_rx with a transaction-level reference model.
module tb_word_sync_rx;

  localparam int unsigned DW = 32;
  localparam int unsigned SS = 2;
  localparam int unsigned CW = 4;

  logic          dclk = 1'b0;
  logic          drst;
  logic          req_tgl;
  logic [DW-1:0] req_data;
  logic          dout_rdy;
  logic          ack_tgl;
  logic [DW-1:0] dout;
  logic          dout_vld;
  logic [CW-1:0] word_cnt;
  logic          proto_err;

  int total = 0;
  int bad   = 0;

  // Reference model: accepted-word count, expected ack level, sticky error, driven level.
  int m_cnt;
  bit m_ack;
  bit m_err;
  bit m_tgl;

  word_sync_rx #(
    .DWIDTH      (DW),
    .SYNC_STAGES (SS),
    .CNT_W       (CW)
  ) dut (
    .dclk      (dclk),
    .drst      (drst),
    .req_tgl   (req_tgl),
    .req_data  (req_data),
    .ack_tgl   (ack_tgl),
    .dout      (dout),
    .dout_vld  (dout_vld),
    .dout_rdy  (dout_rdy),
    .word_cnt  (word_cnt),
    .proto_err (proto_err)
  );

  always #5 dclk = ~dclk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic apply_reset(input bit lvl);
    @(negedge dclk);
    drst     = 1'b1;
    req_tgl  = lvl;
    m_tgl    = lvl;
    dout_rdy = 1'b0;
    repeat (2) @(posedge dclk);
    @(negedge dclk);
    drst = 1'b0;
    repeat (SS + 3) @(negedge dclk);
    m_cnt = 0;
    m_err = 1'b0;
    m_ack = lvl;
  endtask

  // One complete word transfer; delay is the number of not-ready cycles after valid.
  task automatic transfer(input logic [DW-1:0] data, input int delay, input string tag);
    int lat;
    bit got;
    logic [CW-1:0] exp_cnt;
    @(negedge dclk);
    req_data = data;
    m_tgl    = ~m_tgl;
    req_tgl  = m_tgl;
    dout_rdy = (delay == 0);
    lat = 0;
    got = 1'b0;
    @(posedge dclk);  // edge that first samples the new level
    for (int i = 1; i <= 20 && !got; i++) begin
      @(posedge dclk);
      #1;
      if (dout_vld === 1'b1) begin
        got = 1'b1;
        lat = i;
      end
    end
    total++;
    if (!got || lat != SS + 1) begin
      bad++;
      $display("FAIL %s latency: got=%0d (seen=%0b) want=%0d", tag, lat, got, SS + 1);
    end
    total++;
    if (dout !== data) begin
      bad++;
      $display("FAIL %s dout: got=%h want=%h", tag, dout, data);
    end
    for (int i = 0; i < delay; i++) begin
      @(posedge dclk);
      #1;
      total++;
      if (dout_vld !== 1'b1 || dout !== data || ack_tgl !== m_ack) begin
        bad++;
        $display("FAIL %s hold[%0d]: vld=%b dout=%h ack=%b want vld=1 dout=%h ack=%b",
                 tag, i, dout_vld, dout, ack_tgl, data, m_ack);
      end
    end
    if (delay > 0) begin
      @(negedge dclk);
      dout_rdy = 1'b1;
    end
    @(posedge dclk);
    #1;
    m_ack   = ~m_ack;
    m_cnt   = (m_cnt + 1) % (1 << CW);
    exp_cnt = m_cnt[CW-1:0];
    total++;
    if (dout_vld !== 1'b0 || ack_tgl !== m_ack || word_cnt !== exp_cnt) begin
      bad++;
      $display("FAIL %s accept: vld=%b ack=%b cnt=%0d want vld=0 ack=%b cnt=%0d",
               tag, dout_vld, ack_tgl, word_cnt, m_ack, exp_cnt);
    end
    @(negedge dclk);
    dout_rdy = 1'b0;
  endtask

  task automatic test_reset;
    @(negedge dclk);
    drst = 1'b1;
    req_tgl = 1'b0;
    m_tgl = 1'b0;
    @(posedge dclk);
    #1;
    total++;
    if (dout_vld !== 1'b0 || ack_tgl !== 1'b0 || word_cnt !== '0 || proto_err !== 1'b0 ||
        dout !== '0) begin
      bad++;
      $display("FAIL reset_state: vld=%b ack=%b cnt=%0d err=%b dout=%h want all 0",
               dout_vld, ack_tgl, word_cnt, proto_err, dout);
    end
    @(negedge dclk);
    drst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge dclk);
      #1;
      total++;
      if (dout_vld !== 1'b0 || ack_tgl !== 1'b0) begin
        bad++;
        $display("FAIL reset_release[%0d]: vld=%b ack=%b want 0 0", i, dout_vld, ack_tgl);
      end
    end
    m_cnt = 0;
    m_ack = 1'b0;
    m_err = 1'b0;
  endtask

  task automatic test_basic;
    transfer(32'hA5A5_0001, 0, "basic");
    total++;
    if (ack_tgl !== 1'b1 || word_cnt !== 4'd1) begin
      bad++;
      $display("FAIL basic_final: ack=%b cnt=%0d want ack=1 cnt=1", ack_tgl, word_cnt);
    end
  endtask

  task automatic test_rdy_idle;
    logic [CW-1:0] exp_cnt;
    exp_cnt = m_cnt[CW-1:0];
    @(negedge dclk);
    dout_rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge dclk);
      #1;
      total++;
      if (dout_vld !== 1'b0 || word_cnt !== exp_cnt || ack_tgl !== m_ack) begin
        bad++;
        $display("FAIL rdy_idle[%0d]: vld=%b cnt=%0d ack=%b want vld=0 cnt=%0d ack=%b",
                 i, dout_vld, word_cnt, ack_tgl, exp_cnt, m_ack);
      end
    end
    @(negedge dclk);
    dout_rdy = 1'b0;
  endtask

  task automatic test_backpressure;
    transfer($urandom(), 10, "backpressure");
  endtask

  task automatic test_proto_err;
    logic [DW-1:0] d1;
    logic [DW-1:0] d2;
    logic [CW-1:0] exp_cnt;
    bit got;
    d1 = $urandom();
    d2 = ~d1;
    @(negedge dclk);
    req_data = d1;
    m_tgl    = ~m_tgl;
    req_tgl  = m_tgl;
    dout_rdy = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(posedge dclk);
      #1;
      if (dout_vld === 1'b1) got = 1'b1;
    end
    total++;
    if (!got) begin
      bad++;
      $display("FAIL proto_first_vld: vld never rose, want 1");
    end
    @(negedge dclk);
    req_data = d2;
    m_tgl    = ~m_tgl;
    req_tgl  = m_tgl;
    m_err    = 1'b1;
    repeat (5) @(posedge dclk);
    #1;
    total++;
    if (proto_err !== m_err || dout_vld !== 1'b1 || dout !== d1) begin
      bad++;
      $display("FAIL proto_flag: err=%b vld=%b dout=%h want err=1 vld=1 dout=%h",
               proto_err, dout_vld, dout, d1);
    end
    @(negedge dclk);
    dout_rdy = 1'b1;
    @(posedge dclk);
    #1;
    m_ack   = ~m_ack;
    m_cnt   = (m_cnt + 1) % (1 << CW);
    exp_cnt = m_cnt[CW-1:0];
    total++;
    if (dout_vld !== 1'b0 || ack_tgl !== m_ack || word_cnt !== exp_cnt) begin
      bad++;
      $display("FAIL proto_accept: vld=%b ack=%b cnt=%0d want vld=0 ack=%b cnt=%0d",
               dout_vld, ack_tgl, word_cnt, m_ack, exp_cnt);
    end
    for (int i = 0; i < 8; i++) begin
      @(posedge dclk);
      #1;
      total++;
      if (dout_vld !== 1'b0 || proto_err !== 1'b1 || ack_tgl !== m_ack) begin
        bad++;
        $display("FAIL proto_drop[%0d]: vld=%b err=%b ack=%b want vld=0 err=1 ack=%b",
                 i, dout_vld, proto_err, ack_tgl, m_ack);
      end
    end
    @(negedge dclk);
    dout_rdy = 1'b0;
  endtask

  task automatic test_wrap;
    apply_reset(1'b0);
    total++;
    if (proto_err !== 1'b0 || word_cnt !== '0 || ack_tgl !== 1'b0) begin
      bad++;
      $display("FAIL wrap_reset: err=%b cnt=%0d ack=%b want 0 0 0", proto_err, word_cnt, ack_tgl);
    end
    for (int k = 0; k < 17; k++) begin
      transfer($urandom(), int'($urandom_range(0, 3)), "wrap");
    end
    total++;
    if (word_cnt !== 4'd1 || ack_tgl !== 1'b1 || proto_err !== 1'b0) begin
      bad++;
      $display("FAIL wrap_final: cnt=%0d ack=%b err=%b want cnt=1 ack=1 err=0",
               word_cnt, ack_tgl, proto_err);
    end
  endtask

  task automatic test_reset_tgl1;
    apply_reset(1'b1);
    for (int i = 0; i < 6; i++) begin
      @(posedge dclk);
      #1;
      total++;
      if (dout_vld !== 1'b0 || ack_tgl !== 1'b1 || proto_err !== 1'b0) begin
        bad++;
        $display("FAIL tgl1_release[%0d]: vld=%b ack=%b err=%b want vld=0 ack=1 err=0",
                 i, dout_vld, ack_tgl, proto_err);
      end
    end
    transfer($urandom(), 2, "tgl1_xfer");
  endtask

  task automatic test_reset_in_hold;
    bit got;
    @(negedge dclk);
    req_data = $urandom();
    m_tgl    = ~m_tgl;
    req_tgl  = m_tgl;
    dout_rdy = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(posedge dclk);
      #1;
      if (dout_vld === 1'b1) got = 1'b1;
    end
    total++;
    if (!got) begin
      bad++;
      $display("FAIL hold_rst_vld: vld never rose, want 1");
    end
    @(negedge dclk);
    drst = 1'b1;
    @(posedge dclk);
    #1;
    total++;
    if (dout_vld !== 1'b0 || ack_tgl !== 1'b0) begin
      bad++;
      $display("FAIL hold_rst: vld=%b ack=%b want 0 0", dout_vld, ack_tgl);
    end
    @(negedge dclk);
    drst = 1'b0;
    // Mask window: ack holds 0 until the last mask cycle, then adopts the request level.
    for (int i = 1; i <= SS + 1; i++) begin
      @(posedge dclk);
      #1;
      total++;
      if (dout_vld !== 1'b0 || ack_tgl !== ((i == SS + 1) ? m_tgl : 1'b0)) begin
        bad++;
        $display("FAIL hold_mask[%0d]: vld=%b ack=%b want vld=0 ack=%b",
                 i, dout_vld, ack_tgl, (i == SS + 1) ? m_tgl : 1'b0);
      end
    end
    for (int i = 0; i < 5; i++) begin
      @(posedge dclk);
      #1;
      total++;
      if (dout_vld !== 1'b0 || word_cnt !== '0) begin
        bad++;
        $display("FAIL hold_after[%0d]: vld=%b cnt=%0d want 0 0", i, dout_vld, word_cnt);
      end
    end
  endtask

  initial begin
    drst     = 1'b1;
    req_tgl  = 1'b0;
    req_data = '0;
    dout_rdy = 1'b0;
    m_cnt = 0;
    m_ack = 1'b0;
    m_err = 1'b0;
    m_tgl = 1'b0;
    test_reset();
    test_basic();
    test_rdy_idle();
    test_backpressure();
    test_proto_err();
    test_wrap();
    test_reset_tgl1();
    test_reset_in_hold();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/word_sync_rx.md
WORD_SYNC_RX -- requirements
Module: word_sync_rx

Interface
REQ-001 Parameter DWIDTH, default 32, width of the transferred word.
REQ-002 Parameter SYNC_STAGES, default 2, flop count of the req_tgl synchronizer; legal values 2..4.
REQ-003 Parameter CNT_W, default 16, width of word_cnt.
REQ-004 dclk  input  1  destination clock; all state clocked on its rising edge.
REQ-005 drst  input  1  reset, synchronous to dclk, active-high.
REQ-006 req_tgl  input  1  request toggle from the source domain, asynchronous to dclk; each level change announces one new word.
REQ-007 req_data  input  DWIDTH  word from the source domain, asynchronous; stable from before a req_tgl change until the matching ack_tgl change is seen by the source.
REQ-008 ack_tgl  output  1  acknowledge toggle back to the source domain, driven directly from a dclk flop.
REQ-009 dout  output  DWIDTH  captured word.
REQ-010 dout_vld  output  1  dout holds a word not yet accepted.
REQ-011 dout_rdy  input  1  consumer accepts dout when dout_vld and dout_rdy are both high on a dclk edge.
REQ-012 word_cnt  output  CNT_W  count of words accepted by the consumer.
REQ-013 proto_err  output  1  sticky flag: the source violated the handshake.

Function
REQ-014 The block SHALL pass req_tgl through a SYNC_STAGES-deep flop chain (req_s); req_data SHALL NOT be synchronized.
REQ-015 The block SHALL flag an edge when req_s differs from a one-cycle-delayed copy (req_p).
REQ-016 FSM states: MASK, IDLE, HOLD.
REQ-017 MASK: entered on reset; lasts exactly SYNC_STAGES+1 cycles, counted by a down-counter; edges ignored; on exit, req_p and ack_tgl load req_s; next state IDLE.
REQ-018 IDLE: on an edge, dout loads req_data, dout_vld goes to 1 on the next edge, and the FSM moves to HOLD.
REQ-019 HOLD: on dout_vld and dout_rdy, dout_vld goes to 0, ack_tgl inverts, word_cnt increments, and the FSM moves to IDLE, all on the same edge.
REQ-020 dout SHALL stay constant while dout_vld is high.
REQ-021 Latency: dout_vld SHALL be high SYNC_STAGES+1 dclk edges after the first dclk edge that samples the new req_tgl level.
REQ-022 ack_tgl SHALL change only on acceptance, never in MASK after exit, and exactly once per accepted word.
REQ-023 An edge seen in HOLD SHALL set proto_err; that edge is dropped; dout, dout_vld and the FSM are unaffected.
REQ-024 An edge cannot be honoured in the cycle of acceptance; it SHALL be treated as in HOLD (REQ-023).
REQ-025 word_cnt SHALL wrap from 2^CNT_W-1 to 0 with no flag.
REQ-026 dout_rdy while dout_vld is low SHALL have no effect.

Reset
REQ-027 While drst is high on a dclk edge: sync chain, req_p, ack_tgl, dout, dout_vld, word_cnt and proto_err SHALL clear to 0; the FSM SHALL enter MASK with the counter at SYNC_STAGES+1.
REQ-028 Reset mid-transfer SHALL discard any held word without toggling ack_tgl.
REQ-029 The MASK resync (REQ-017) SHALL prevent a spurious capture when req_tgl is 1 at reset release.

Structure
REQ-030 A shared package SHALL hold the FSM state enum (MASK, IDLE, HOLD) and the default parameter constants.
REQ-031 The synchronizer SHALL be a sub-module, sync_bit (params STAGES; ports dclk, drst, din, dout), reusable by the source-side block.
REQ-032 Only flops inside sync_bit SHALL sample asynchronous inputs.

Verification
REQ-033 Reset, req_tgl=0: toggle req_tgl with req_data=0xA5A5_0001, dout_rdy=1 -> dout_vld high 3 edges after sampling, dout=0xA5A5_0001, ack_tgl 0->1 on acceptance, word_cnt=1.
REQ-034 Backpressure: dout_rdy=0 for 10 cycles after capture -> dout_vld and dout held; ack_tgl unchanged until dout_rdy rises.
REQ-035 Protocol violation: second req_tgl toggle while in HOLD -> proto_err=1 and stays 1; the first word is still delivered once; word_cnt increments by 1.
REQ-036 Reset release with req_tgl=1 -> no dout_vld, ack_tgl=1 after MASK, proto_err=0.
REQ-037 CNT_W=4: 17 full transfers -> word_cnt=1; ack_tgl equals the parity of 17 (i.e. 1).
REQ-038 Reset asserted while in HOLD -> dout_vld=0 and ack_tgl=0 the next cycle; the FSM is in MASK.
